// File: rtl/regfile_bist_pkg.sv
// rtl/regfile_bist_pkg.sv - shared phase encoding, widths and march pattern for regfile_bist
package regfile_bist_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    W0   = 3'd1,
    R0   = 3'd2,
    WD   = 3'd3,
    R1   = 3'd4,
    W1   = 3'd5,
    R2   = 3'd6
  } phase_e;

  localparam int ERR_W = 8;
  localparam int MAX_W = 64;

  // rotl(seed, a mod width) ^ a, evaluated in the low `width` bits of a MAX_W vector
  function automatic logic [MAX_W-1:0] pattern(input int width, input logic [MAX_W-1:0] seed,
                                               input int a);
    logic [MAX_W-1:0] r;
    int s;
    r = '0;
    s = a % width;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < width) r[(i + s) % width] = seed[i];
    end
    return r ^ MAX_W'(a);
  endfunction

endpackage

// File: rtl/regfile_bist_checker.sv
// rtl/regfile_bist_checker.sv - two-port compare, saturating error count, first-fail capture
module regfile_bist_checker
  import regfile_bist_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              check_en,
  input  phase_e            phase,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [WIDTH-1:0]  data1,
  input  logic [WIDTH-1:0]  data2,
  input  logic [WIDTH-1:0]  exp1,
  input  logic [WIDTH-1:0]  exp2,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] fail_addr,
  output phase_e            fail_phase,
  output logic              fail_port
);

  localparam logic [ERR_W+1:0] ERR_MAX = {2'b00, {ERR_W{1'b1}}};

  logic             mis1, mis2, has_fail;
  logic [ERR_W+1:0] err_sum;

  assign mis1    = check_en && (data1 != exp1);
  assign mis2    = check_en && (data2 != exp2);
  assign err_sum = {2'b00, err_count} + {{(ERR_W+1){1'b0}}, mis1} + {{(ERR_W+1){1'b0}}, mis2};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count  <= '0;
      fail_addr  <= '0;
      fail_phase <= IDLE;
      fail_port  <= 1'b0;
      has_fail   <= 1'b0;
    end else if (clear) begin
      err_count  <= '0;
      fail_addr  <= '0;
      fail_phase <= IDLE;
      fail_port  <= 1'b0;
      has_fail   <= 1'b0;
    end else begin
      err_count <= (err_sum > ERR_MAX) ? ERR_MAX[ERR_W-1:0] : err_sum[ERR_W-1:0];
      // port 1 takes priority when both ports miss in the same cycle
      if (!has_fail && (mis1 || mis2)) begin
        has_fail   <= 1'b1;
        fail_addr  <= mis1 ? addr1 : addr2;
        fail_port  <= !mis1;
        fail_phase <= phase;
      end
    end
  end

endmodule

// File: rtl/regfile_bist.sv
// rtl/regfile_bist.sv - six-phase march BIST engine driving the register file ports
module regfile_bist
  import regfile_bist_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 32,
  parameter bit               ZERO_REG = 1'b1,
  parameter logic [WIDTH-1:0] SEED     = WIDTH'(32'hA5C30F96),
  localparam int              ADDR_W   = $clog2(DEPTH)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  output logic              Busy,
  output logic              Done,
  output logic              Pass,
  output logic [ERR_W-1:0]  ErrCount,
  output logic [ADDR_W-1:0] FailAddr,
  output logic [2:0]        FailPhase,
  output logic              FailPort,
  output logic [WIDTH-1:0]  WriteData,
  output logic [ADDR_W-1:0] WriteRegister,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] ReadRegister1,
  output logic [ADDR_W-1:0] ReadRegister2,
  input  logic [WIDTH-1:0]  ReadData1,
  input  logic [WIDTH-1:0]  ReadData2
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  phase_e            state, state_nxt, fail_phase;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic              start_ok, check_en;
  logic [WIDTH-1:0]  pat_nxt, wd_nxt, exp1, exp2;
  logic [ADDR_W-1:0] wr_nxt, rr1_nxt, rr2_nxt;
  logic              we_nxt;

  function automatic logic [WIDTH-1:0] pat(input logic [ADDR_W-1:0] a);
    return WIDTH'(pattern(WIDTH, MAX_W'(SEED), int'(a)));
  endfunction

  function automatic logic [WIDTH-1:0] expect_val(input phase_e ph, input logic [ADDR_W-1:0] r);
    if (ZERO_REG && r == '0) return '0;
    return (ph == R2) ? ~pat(r) : pat(r);
  endfunction

  assign start_ok = Start && (state == IDLE);
  assign Busy     = (state != IDLE);
  assign Pass     = Done && (ErrCount == '0);
  assign check_en = (state == R0) || (state == R1) || (state == R2);
  assign exp1     = expect_val(state, ReadRegister1);
  assign exp2     = expect_val(state, ReadRegister2);
  assign FailPhase = fail_phase;

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    if (start_ok) begin
      state_nxt = W0;
      addr_nxt  = '0;
    end else if (state != IDLE) begin
      addr_nxt = addr + 1'b1;
      if (addr == LAST) begin
        case (state)
          W0:      state_nxt = R0;
          R0:      state_nxt = WD;
          WD:      state_nxt = R1;
          R1:      state_nxt = W1;
          W1:      state_nxt = R2;
          default: state_nxt = IDLE;
        endcase
      end
    end
  end

  // port drive is computed from the next state so the registered outputs line up with it
  always_comb begin
    pat_nxt = pat(addr_nxt);
    wd_nxt  = '0;
    wr_nxt  = '0;
    we_nxt  = 1'b0;
    rr1_nxt = '0;
    rr2_nxt = '0;
    case (state_nxt)
      W0: begin
        wr_nxt = addr_nxt; wd_nxt = pat_nxt;  we_nxt = 1'b1;
      end
      WD: begin
        wr_nxt = addr_nxt; wd_nxt = ~pat_nxt;
      end
      W1: begin
        wr_nxt = addr_nxt; wd_nxt = ~pat_nxt; we_nxt = 1'b1;
      end
      R0, R1, R2: begin
        rr1_nxt = addr_nxt; rr2_nxt = LAST - addr_nxt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state         <= IDLE;
      addr          <= '0;
      Done          <= 1'b0;
      WriteData     <= '0;
      WriteRegister <= '0;
      RegWrite      <= 1'b0;
      ReadRegister1 <= '0;
      ReadRegister2 <= '0;
    end else begin
      state         <= state_nxt;
      addr          <= addr_nxt;
      WriteData     <= wd_nxt;
      WriteRegister <= wr_nxt;
      RegWrite      <= we_nxt;
      ReadRegister1 <= rr1_nxt;
      ReadRegister2 <= rr2_nxt;
      if (start_ok)                          Done <= 1'b0;
      else if (state == R2 && addr == LAST)  Done <= 1'b1;
    end
  end

  regfile_bist_checker #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_checker (
    .clk        (Clk),
    .rst        (Reset),
    .clear      (start_ok),
    .check_en   (check_en),
    .phase      (state),
    .addr1      (ReadRegister1),
    .addr2      (ReadRegister2),
    .data1      (ReadData1),
    .data2      (ReadData2),
    .exp1       (exp1),
    .exp2       (exp2),
    .err_count  (ErrCount),
    .fail_addr  (FailAddr),
    .fail_phase (fail_phase),
    .fail_port  (FailPort)
  );

endmodule

// File: tb/tb_regfile_bist.sv
// tb/tb_regfile_bist.sv - directed bench for regfile_bist against a faultable register file model
module tb_regfile_bist;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy, done, pass, fail_port, reg_write;
  logic [7:0]  err_count;
  logic [4:0]  fail_addr, write_register, read_register1, read_register2;
  logic [2:0]  fail_phase;
  logic [31:0] write_data, read_data1, read_data2;

  // 0 correct, 1 reads stuck at 42, 2 ignores RegWrite, 3 reg 7 bit 5 stuck-at-0
  int          mode;
  logic [31:0] rf [32];
  int          errors = 0;
  int          checks = 0;
  int          n;
  logic        done_first;

  regfile_bist dut (
    .Clk           (clk),
    .Reset         (rst),
    .Start         (start),
    .Busy          (busy),
    .Done          (done),
    .Pass          (pass),
    .ErrCount      (err_count),
    .FailAddr      (fail_addr),
    .FailPhase     (fail_phase),
    .FailPort      (fail_port),
    .WriteData     (write_data),
    .WriteRegister (write_register),
    .RegWrite      (reg_write),
    .ReadRegister1 (read_register1),
    .ReadRegister2 (read_register2),
    .ReadData1     (read_data1),
    .ReadData2     (read_data2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reg_write || mode == 2) rf[write_register] <= write_data;
  end

  function automatic logic [31:0] rf_read(input logic [4:0] a);
    logic [31:0] v;
    if (mode == 1) return 32'd42;
    if (a == 5'd0) return 32'd0;
    v = rf[a];
    if (mode == 3 && a == 5'd7) v[5] = 1'b0;
    return v;
  endfunction

  always_comb begin
    read_data1 = rf_read(read_register1);
    read_data2 = rf_read(read_register2);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one Start pulse, then count cycles with Busy; a pulse is replayed when extra cycles have elapsed
  task automatic run(input int extra, output int cycles, output logic done_at_first);
    @(negedge clk);
    start = 1'b1;
    cycles = 0;
    done_at_first = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      start = (extra > 0 && cycles == extra);
      if (i == 0) done_at_first = done;
      if (!busy) break;
      cycles++;
    end
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    mode = 0;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_count, 0);
    check("rst_fail_addr", fail_addr, 0);
    check("rst_fail_phase", fail_phase, 0);
    check("rst_fail_port", fail_port, 0);
    check("rst_reg_write", reg_write, 0);
    check("rst_write_data", write_data, 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_rr2", read_register2, 0);

    // first W0 cycles: P(0)=A5C30F96, P(1)=rotl1^1=4B861F2C
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("w0_busy", busy, 1);
    check("w0_reg_write", reg_write, 1);
    check("w0_addr0", write_register, 0);
    check("w0_data0", write_data, 32'hA5C30F96);
    @(negedge clk);
    check("w0_addr1", write_register, 1);
    check("w0_data1", write_data, 32'h4B861F2C);
    n = 2;
    for (int i = 0; i < 1000 && busy; i++) begin
      @(negedge clk);
      if (busy) n++;
    end
    check("t1_busy_cycles", n, 192);
    check("t1_done", done, 1);
    check("t1_pass", pass, 1);
    check("t1_err", err_count, 0);
    check("t1_reg_write", reg_write, 0);

    run(100, n, done_first);
    check("t2_done_cleared", done_first, 0);
    check("t2_busy_cycles", n, 192);
    check("t2_pass", pass, 1);
    check("t2_err", err_count, 0);

    mode = 1;
    run(0, n, done_first);
    check("t3_pass", pass, 0);
    check("t3_phase", fail_phase, 2);
    check("t3_addr", fail_addr, 0);
    check("t3_port", fail_port, 0);
    check("t3_err", err_count, 192);

    mode = 2;
    run(0, n, done_first);
    check("t4_pass", pass, 0);
    check("t4_phase", fail_phase, 4);
    check("t4_addr", fail_addr, 31);
    check("t4_port", fail_port, 1);
    check("t4_err", err_count, 62);

    // bit 5 of P(7) is 0, so only ~P in R2 exposes it (ports 1 and 2 once each)
    mode = 3;
    run(0, n, done_first);
    check("t5_pass", pass, 0);
    check("t5_phase", fail_phase, 6);
    check("t5_addr", fail_addr, 7);
    check("t5_port", fail_port, 0);
    check("t5_err", err_count, 2);

    mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (49) @(negedge clk);
    check("t6_busy_before", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("t6_reg_write", reg_write, 0);
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_err", err_count, 0);
    @(negedge clk);
    rst = 1'b0;
    run(0, n, done_first);
    check("t6_busy_cycles", n, 192);
    check("t6_pass", pass, 1);
    check("t6_err_after", err_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
